fetch_unit: RTL and testbench

- Instruction-fetch and PC-sequencing stage of the single-issue 16-bit processor.
- Owns the PC and runs the instruction-memory read handshake.
- Latches each 16-bit instruction and presents its opcode to the opcode-decode controller. Resolves B/JAL/JR/HLT next-PC from condition flags and the register-file JR operand.

---
 rtl/isa_pkg.sv | 39 +++
 rtl/branch_cond.sv | 27 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core: opcodes, branch condition codes
// and the fetch-stage state encoding.
package isa_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SLA = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LI  = 4'h8;
  localparam logic [3:0] OP_LUI = 4'h9;
  localparam logic [3:0] OP_LW  = 4'hA;
  localparam logic [3:0] OP_SW  = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GTE = 3'b100;
  localparam logic [2:0] CC_LTE = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UN  = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a 3-bit condition code and the Z/N/V flags
// to a taken decision. Purely combinational.
module branch_cond
  import isa_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic       i_flag_z,
  input  logic       i_flag_n,
  input  logic       i_flag_v,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_ccc)
      CC_NE:   o_taken = !i_flag_z;
      CC_EQ:   o_taken = i_flag_z;
      CC_GT:   o_taken = !i_flag_z && !i_flag_n;
      CC_LT:   o_taken = i_flag_n;
      CC_GTE:  o_taken = i_flag_z || (!i_flag_z && !i_flag_n);
      CC_LTE:  o_taken = i_flag_n || i_flag_z;
      CC_OV:   o_taken = i_flag_v;
      default: o_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: owns the PC, runs the instruction-memory
// read, holds the live instruction and resolves B/JAL/JR/HLT next-PC.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int                PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               im_rd_en,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               im_rdy,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus2,
  input  logic               flag_z,
  input  logic               flag_v,
  input  logic               flag_n,
  input  logic [PC_W-1:0]    jr_target,
  input  logic               ex_stall,
  output logic               branch_taken,
  output logic               halted,
  output fetch_state_e       o_dbg_state
);

  fetch_state_e      r_state;
  logic [PC_W-1:0]   r_pc;
  logic [INSTR_W-1:0] r_instr;

  logic [PC_W-1:0]   w_pc_plus2;
  logic [PC_W-1:0]   w_b_off;
  logic [PC_W-1:0]   w_j_off;
  logic [PC_W-1:0]   w_next_pc;
  logic              w_redirect;
  logic              w_cond_taken;
  logic              w_commit;

  // Memory handshake: im_rd_en is a level request held for every S_FETCH cycle
  // with im_addr stable; the cycle im_rdy is seen high completes the read and
  // im_rdata is captured on that edge. im_rdy in any other state is ignored.
  assign im_rd_en     = (r_state == S_FETCH) && rst_n;
  assign im_addr      = r_pc;
  assign instr        = r_instr;
  assign opcode       = r_instr[15:12];
  assign instr_valid  = (r_state == S_EXEC);
  assign halted       = (r_state == S_HALT);
  assign pc           = r_pc;
  assign pc_plus2     = w_pc_plus2;
  assign o_dbg_state  = r_state;

  assign w_pc_plus2 = r_pc + PC_W'(2);
  assign w_b_off    = {{(PC_W-10){r_instr[8]}}, r_instr[8:0], 1'b0};
  assign w_j_off    = {{(PC_W-13){r_instr[11]}}, r_instr[11:0], 1'b0};

  branch_cond u_branch_cond (
    .i_ccc    (r_instr[11:9]),
    .i_flag_z (flag_z),
    .i_flag_n (flag_n),
    .i_flag_v (flag_v),
    .o_taken  (w_cond_taken)
  );

  always_comb begin
    w_next_pc  = w_pc_plus2;
    w_redirect = 1'b0;
    case (r_instr[15:12])
      OP_B: begin
        w_redirect = w_cond_taken;
        if (w_cond_taken) w_next_pc = w_pc_plus2 + w_b_off;
      end
      OP_JAL: begin
        w_redirect = 1'b1;
        w_next_pc  = w_pc_plus2 + w_j_off;
      end
      OP_JR: begin
        w_redirect = 1'b1;
        w_next_pc  = jr_target & ~PC_W'(1);
      end
      default: ;
    endcase
  end

  // Flags and jr_target only matter in the last exec cycle, when the stall drops.
  assign w_commit     = (r_state == S_EXEC) && !ex_stall;
  assign branch_taken = w_commit && w_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (im_rdy) begin
            r_instr <= im_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_commit) begin
            if (r_instr[15:12] == OP_HLT) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_FETCH;
            end
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, memory wait, branches,
// JAL/JR, stall, halt and asynchronous reset.
module tb_fetch_unit;
  import isa_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        im_rd_en;
  logic [15:0] im_addr;
  logic [15:0] im_rdata;
  logic        im_rdy;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        flag_z, flag_v, flag_n;
  logic [15:0] jr_target;
  logic        ex_stall;
  logic        branch_taken;
  logic        halted;
  fetch_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .im_rd_en     (im_rd_en),
    .im_addr      (im_addr),
    .im_rdata     (im_rdata),
    .im_rdy       (im_rdy),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .flag_n       (flag_n),
    .jr_target    (jr_target),
    .ex_stall     (ex_stall),
    .branch_taken (branch_taken),
    .halted       (halted),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; im_rdy = 1'b0; im_rdata = '0; ex_stall = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0; jr_target = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Completes one fetch with im_rdy high in the first cycle; leaves DUT in exec.
  task automatic fetch(input logic [15:0] ins);
    im_rdy = 1'b1;
    im_rdata = ins;
    step();
    im_rdy = 1'b0;
    im_rdata = '0;
  endtask

  task automatic commit();
    ex_stall = 1'b0;
    step();
  endtask

  task automatic goto_pc(input logic [15:0] t);
    fetch(16'hE000);
    jr_target = t;
    commit();
    jr_target = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; im_rdy = 1'b1; im_rdata = 16'hABCD; ex_stall = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0; jr_target = '0;
    #3;
    n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %h want 0000", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", branch_taken); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (im_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", im_rd_en); end
    n_cmp++; if (dbg_state !== S_FETCH) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_FETCH); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL reset_rdy_ignored: got %h want 0000", instr); end
    im_rdy = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (im_rd_en !== 1'b1) begin n_err++; $display("FAIL post_reset_rd_en: got %b want 1", im_rd_en); end
    n_cmp++; if (im_addr !== 16'h0000) begin n_err++; $display("FAIL post_reset_addr: got %h want 0000", im_addr); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    do_reset();
    exp_pc = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", k, im_addr, exp_pc); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_fetch_valid[%0d]: got %b want 0", k, instr_valid); end
      fetch(16'h0123);
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_exec_valid[%0d]: got %b want 1", k, instr_valid); end
      n_cmp++; if (instr !== 16'h0123) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want 0123", k, instr); end
      n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL seq_opcode[%0d]: got %h want 0", k, opcode); end
      n_cmp++; if (pc_plus2 !== exp_pc + 16'h2) begin n_err++; $display("FAIL seq_pc_plus2[%0d]: got %h want %h", k, pc_plus2, exp_pc + 16'h2); end
      n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL seq_taken[%0d]: got %b want 0", k, branch_taken); end
      commit();
      exp_pc = exp_pc + 16'h2;
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", k, pc, exp_pc); end
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      im_rdy = 1'b0;
      #1;
      n_cmp++; if (im_rd_en !== 1'b1) begin n_err++; $display("FAIL wait_rd_en[%0d]: got %b want 1", i, im_rd_en); end
      n_cmp++; if (im_addr !== 16'h0000) begin n_err++; $display("FAIL wait_addr[%0d]: got %h want 0000", i, im_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
      step();
    end
    im_rdy = 1'b1; im_rdata = 16'h1234;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid_4th: got %b want 0", instr_valid); end
    step();
    im_rdy = 1'b0;
    n_cmp++; if (instr !== 16'h1234) begin n_err++; $display("FAIL wait_instr: got %h want 1234", instr); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL wait_exec_valid: got %b want 1", instr_valid); end
    ex_stall = 1'b1; im_rdy = 1'b1; im_rdata = 16'h5555;
    step();
    im_rdy = 1'b0;
    n_cmp++; if (instr !== 16'h1234) begin n_err++; $display("FAIL exec_rdy_ignored: got %h want 1234", instr); end
    commit();
    n_cmp++; if (pc !== 16'h0002) begin n_err++; $display("FAIL wait_next_pc: got %h want 0002", pc); end
  endtask

  task automatic test_branch();
    logic [15:0] exp_pc;
    logic        exp_tk;
    logic [2:0]  cc;
    logic        z, n, v;
    do_reset();
    goto_pc(16'h0010);
    // EQ, offset 9'h1FD = -3 halfwords: 0012 - 6 = 000C
    fetch(16'hC3FD);
    flag_z = 1'b1;
    #1;
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL b_eq_taken: got %b want 1", branch_taken); end
    commit();
    n_cmp++; if (pc !== 16'h000C) begin n_err++; $display("FAIL b_eq_pc: got %h want 000C", pc); end
    goto_pc(16'h0010);
    fetch(16'hC3FD);
    flag_z = 1'b0;
    #1;
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL b_ne_taken: got %b want 0", branch_taken); end
    commit();
    n_cmp++; if (pc !== 16'h0012) begin n_err++; $display("FAIL b_ne_pc: got %h want 0012", pc); end

    // Sweep all conditions over all flag combinations, offset +4 halfwords.
    exp_pc = 16'h0012;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        cc = 3'(c);
        z = f[2]; n = f[1]; v = f[0];
        case (cc)
          3'd0: exp_tk = ~z;
          3'd1: exp_tk = z;
          3'd2: exp_tk = ~z & ~n;
          3'd3: exp_tk = n;
          3'd4: exp_tk = z | ~n;
          3'd5: exp_tk = n | z;
          3'd6: exp_tk = v;
          default: exp_tk = 1'b1;
        endcase
        fetch({4'hC, cc, 9'h004});
        flag_z = z; flag_n = n; flag_v = v;
        #1;
        n_cmp++; if (branch_taken !== exp_tk) begin n_err++; $display("FAIL sweep_taken ccc=%0d znv=%0d%0d%0d: got %b want %b", c, z, n, v, branch_taken, exp_tk); end
        commit();
        exp_pc = exp_pc + 16'h2 + (exp_tk ? 16'h8 : 16'h0);
        n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL sweep_pc ccc=%0d znv=%0d%0d%0d: got %h want %h", c, z, n, v, pc, exp_pc); end
      end
    end
    flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
  endtask

  task automatic test_jal_jr();
    do_reset();
    goto_pc(16'h0020);
    fetch(16'hD004);
    n_cmp++; if (pc_plus2 !== 16'h0022) begin n_err++; $display("FAIL jal_link: got %h want 0022", pc_plus2); end
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL jal_taken: got %b want 1", branch_taken); end
    commit();
    n_cmp++; if (pc !== 16'h002A) begin n_err++; $display("FAIL jal_pc: got %h want 002A", pc); end
    fetch(16'hE000);
    jr_target = 16'h1235;
    #1;
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL jr_taken: got %b want 1", branch_taken); end
    commit();
    jr_target = '0;
    n_cmp++; if (pc !== 16'h1234) begin n_err++; $display("FAIL jr_pc: got %h want 1234", pc); end
    // JAL imm -1: 1236 - 2 = 1234
    fetch(16'hDFFF);
    commit();
    n_cmp++; if (pc !== 16'h1234) begin n_err++; $display("FAIL jal_neg_pc: got %h want 1234", pc); end
    goto_pc(16'hFFFE);
    fetch(16'h0123);
    n_cmp++; if (pc_plus2 !== 16'h0000) begin n_err++; $display("FAIL wrap_plus2: got %h want 0000", pc_plus2); end
    commit();
    n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", pc); end
  endtask

  task automatic test_stall();
    do_reset();
    goto_pc(16'h0010);
    fetch(16'hC3FD);
    flag_z = 1'b0; ex_stall = 1'b1;
    #1;
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL stall_taken0: got %b want 0", branch_taken); end
    step();
    n_cmp++; if (pc !== 16'h0010) begin n_err++; $display("FAIL stall_pc0: got %h want 0010", pc); end
    n_cmp++; if (instr !== 16'hC3FD) begin n_err++; $display("FAIL stall_instr0: got %h want C3FD", instr); end
    flag_z = 1'b1;
    #1;
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL stall_taken1: got %b want 0", branch_taken); end
    step();
    n_cmp++; if (pc !== 16'h0010) begin n_err++; $display("FAIL stall_pc1: got %h want 0010", pc); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
    ex_stall = 1'b0;
    #1;
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL stall_commit_taken: got %b want 1", branch_taken); end
    step();
    n_cmp++; if (pc !== 16'h000C) begin n_err++; $display("FAIL stall_commit_pc: got %h want 000C", pc); end
    // Opposite case: flags true during stall, false at commit.
    goto_pc(16'h0010);
    fetch(16'hC3FD);
    flag_z = 1'b1; ex_stall = 1'b1;
    step();
    flag_z = 1'b0;
    commit();
    n_cmp++; if (pc !== 16'h0012) begin n_err++; $display("FAIL stall_late_flag_pc: got %h want 0012", pc); end
  endtask

  task automatic test_halt_reset();
    do_reset();
    goto_pc(16'h0030);
    fetch(16'hF000);
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL hlt_taken: got %b want 0", branch_taken); end
    commit();
    for (int i = 0; i < 4; i++) begin
      im_rdy = 1'b1; im_rdata = 16'h0123;
      #1;
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL hlt_halted[%0d]: got %b want 1", i, halted); end
      n_cmp++; if (pc !== 16'h0030) begin n_err++; $display("FAIL hlt_pc[%0d]: got %h want 0030", i, pc); end
      n_cmp++; if (im_rd_en !== 1'b0) begin n_err++; $display("FAIL hlt_rd_en[%0d]: got %b want 0", i, im_rd_en); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL hlt_valid[%0d]: got %b want 0", i, instr_valid); end
      step();
    end
    im_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL hlt_rst_halted: got %b want 0", halted); end
    n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL hlt_rst_pc: got %h want 0000", pc); end
    step();
    rst_n = 1'b1;
    #1;
    goto_pc(16'h0040);
    im_rdy = 1'b1; im_rdata = 16'h0123;
    #1;
    n_cmp++; if (im_addr !== 16'h0040) begin n_err++; $display("FAIL midfetch_addr: got %h want 0040", im_addr); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL midfetch_rst_pc: got %h want 0000", pc); end
    n_cmp++; if (im_rd_en !== 1'b0) begin n_err++; $display("FAIL midfetch_rst_rd_en: got %b want 0", im_rd_en); end
    step();
    im_rdy = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL midfetch_instr: got %h want 0000", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL midfetch_valid: got %b want 0", instr_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL midfetch_halted: got %b want 0", halted); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0; im_rdy = 1'b0; im_rdata = '0; ex_stall = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0; jr_target = '0;
    #2;
    test_reset();
    test_sequential();
    test_mem_wait();
    test_branch();
    test_jal_jr();
    test_stall();
    test_halt_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
